mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. Sequences one instruction over 3-5+ cycles.
//  Produces the ALUOp code consumed by the ALU control decoder, plus mux selects and write enables.
//  Sits beside the datapath and the shared instruction/data memory.
//  Stalls on a memory-ready handshake.
// PARAMETERS
//  USE_MEM_READY  1  1: FETCH/MEMRD/MEMWR wait for MemReady; 0: MemReady ignored (treated as 1)
// PORTS
//  clk       in   1  single clock, all state updates on rising edge
//  reset     in   1  synchronous, active-high
//  Op        in   6  opcode field, IR[31:26], valid from DECODE onward (IR stable)
//  Zero      in   1  ALU zero flag, sampled combinationally in BEQ
//  MemReady  in   1  memory has completed current read/write this cycle
//  PCEn      out  1  PC register enable = PCWrite | (Branch & Zero)
//  IorD      out  1  memory address select: 0=PC, 1=ALUOut
//  MemWrite  out  1  memory write strobe
//  IRWrite   out  1  instruction register load
//  RegDst    out  1  0=rt, 1=rd
//  MemtoReg  out  1  0=ALUOut, 1=MDR
//  RegWrite  out  1  register file write enable
//  ALUSrcA   out  1  0=PC, 1=A
//  ALUSrcB   out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
//  ALUOp     out  2  00=add, 01=sub, 10=use Funct
//  PCSrc     out  2  00=ALUResult, 01=ALUOut, 10=jump target
//  InstrDone out  1  one-cycle pulse on the last cycle of each instruction
//  IllegalOp out  1  one-cycle pulse in DECODE when Op is unsupported
//  State     out  4  current state, debug
// BEHAVIOUR
//  - Reset: State<=FETCH; while reset=1 all enables (PCEn, MemWrite, IRWrite, RegWrite) and pulses
//    are forced 0. Muxes take FETCH values.
//  - Outputs are Moore-decoded from State, except PCEn (uses Zero) and the MemReady gating below.
//    Unlisted outputs are 0.
//  - States (4-bit encoding):
//    FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9,
//    ADDIWB=10, JUMP=11. Codes 12-15 -> FETCH next cycle, no writes.
//  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
//    IRWrite=PCWrite=MemReady; ->DECODE if MemReady, else hold.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op:
//    lw 100011 / sw 101011 ->MEMADR; R 000000 ->EXEC; beq 000100 ->BEQ; addi 001000 ->ADDIEX;
//    j 000010 ->JUMP; other ->FETCH with IllegalOp=1 (instruction retired as NOP, InstrDone=1).
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; Op==lw ->MEMRD, else ->MEMWR.
//  - MEMRD: IorD=1; ->MEMWB when MemReady, else hold.
//  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, InstrDone=1; ->FETCH.
//  - MEMWR: IorD=1; MemWrite held 1 until the MemReady cycle; then InstrDone=1, ->FETCH.
//  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; ->ALUWB.
//  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, InstrDone=1; ->FETCH.
//  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, InstrDone=1; ->FETCH.
//  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; ->ADDIWB.
//  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, InstrDone=1; ->FETCH.
//  - JUMP: PCSrc=10, PCWrite=1, InstrDone=1; ->FETCH.
//  - Latency with MemReady=1 (cycles incl. FETCH): beq/j 3, R/addi/sw 4, lw 5.
//    Each MemReady=0 cycle adds one.
//  - Reset mid-instruction: next edge -> FETCH, no partial write occurs in the reset cycle.
//  - Op is read only in DECODE and MEMADR; changes elsewhere are ignored.
// STRUCTURE
//  - Shared package mips_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J),
//    ALUOp codes (ALUOP_ADD/SUB/FUNCT), ALUSrcB/PCSrc select codes, state localparams.
//  - Single state register + next-state block + output decode; no sub-module.
//  - PCEn AND/OR stays in this block.
// TESTING
//  1 reset=1 for 2 cycles, MemReady=1 -> State=0, RegWrite=MemWrite=IRWrite=PCEn=0; release
//    -> IRWrite=1 next cycle.
//  2 Op=000000, MemReady=1 -> State 0,1,6,7,0; ALUOp=10 in EXEC; RegWrite=1, RegDst=1,
//    InstrDone=1 in ALUWB.
//  3 Op=100011, MemReady low 2 cycles in MEMRD -> States 0,1,2,3,3,3,4,0;
//    RegWrite only in MEMWB, MemtoReg=1.
//  4 Op=000100, Zero=1 then repeat with Zero=0 -> BEQ: ALUOp=01, PCSrc=01; PCEn=1 / PCEn=0.
//  5 Op=101011, MemReady=0 one cycle in MEMWR -> MemWrite=1 for 2 cycles, InstrDone on 2nd;
//    Op=000010 -> PCSrc=10, PCEn=1.
//  6 Op=111111 -> IllegalOp=1 in DECODE, next State=0, no write; reset asserted in MEMWR
//    -> MemWrite=0 same cycle, State=0 next.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants for the multicycle MIPS control path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXEC   = 4'd6;
    localparam logic [3:0] ST_ALUWB  = 4'd7;
    localparam logic [3:0] ST_BEQ    = 4'd8;
    localparam logic [3:0] ST_ADDIEX = 4'd9;
    localparam logic [3:0] ST_ADDIWB = 4'd10;
    localparam logic [3:0] ST_JUMP   = 4'd11;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_control.sv
// ============================================================================
// Module      : mips_multicycle_control
// Description : Main control FSM of the multicycle MIPS datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       InstrDone,
    output logic       IllegalOp,
    output logic [3:0] State
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_mem_ready;
    logic       w_pcwrite;
    logic       w_branch;

    generate
        if (USE_MEM_READY != 0) begin : g_mem_ready
            assign w_mem_ready = MemReady;
        end else begin : g_no_mem_ready
            assign w_mem_ready = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_FETCH:  w_next = w_mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: w_next = ST_MEMADR;
                    OP_RTYPE:     w_next = ST_EXEC;
                    OP_BEQ:       w_next = ST_BEQ;
                    OP_ADDI:      w_next = ST_ADDIEX;
                    OP_J:         w_next = ST_JUMP;
                    default:      w_next = ST_FETCH;
                endcase
            end
            ST_MEMADR: w_next = (Op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  w_next = w_mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:  w_next = w_mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   w_next = ST_ALUWB;
            ST_ADDIEX: w_next = ST_ADDIWB;
            default:   w_next = ST_FETCH;
        endcase
    end

    // Reset overrides the decode: muxes show FETCH values, every strobe is low.
    always_comb begin
        IorD      = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_B;
        ALUOp     = ALUOP_ADD;
        PCSrc     = PCSRC_ALU;
        InstrDone = 1'b0;
        IllegalOp = 1'b0;
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        if (reset) begin
            ALUSrcB = SRCB_FOUR;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    ALUSrcB   = SRCB_FOUR;
                    IRWrite   = w_mem_ready;
                    w_pcwrite = w_mem_ready;
                end
                ST_DECODE: begin
                    ALUSrcB = SRCB_IMM_SH2;
                    if (!is_legal_op(Op)) begin
                        IllegalOp = 1'b1;
                        InstrDone = 1'b1;
                    end
                end
                ST_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                ST_MEMRD: IorD = 1'b1;
                ST_MEMWB: begin
                    MemtoReg  = 1'b1;
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                ST_MEMWR: begin
                    IorD      = 1'b1;
                    MemWrite  = 1'b1;
                    InstrDone = w_mem_ready;
                end
                ST_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                ST_ALUWB: begin
                    RegDst    = 1'b1;
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                ST_BEQ: begin
                    ALUSrcA   = 1'b1;
                    ALUOp     = ALUOP_SUB;
                    PCSrc     = PCSRC_ALUOUT;
                    w_branch  = 1'b1;
                    InstrDone = 1'b1;
                end
                ST_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                ST_ADDIWB: begin
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                ST_JUMP: begin
                    PCSrc     = PCSRC_JUMP;
                    w_pcwrite = 1'b1;
                    InstrDone = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign PCEn  = w_pcwrite | (w_branch & Zero);
    assign State = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
// ============================================================================
// Module      : tb_mips_multicycle_control
// Description : Directed self-checking bench for the multicycle control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       InstrDone, IllegalOp;
    logic [3:0] State;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(.USE_MEM_READY(1)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
        .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .InstrDone(InstrDone),
        .IllegalOp(IllegalOp), .State(State)
    );

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    // Each test starts and ends just after a falling edge with the FSM in FETCH.
    task automatic test_reset();
        reset = 1'b1; MemReady = 1'b1; Op = 6'b000000; Zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_total++; if (State !== 4'd0) $display("FAIL reset_state: got %0d expected 0", State); else n_pass++;
        n_total++; if ({RegWrite, MemWrite, IRWrite, PCEn} !== 4'b0000)
            $display("FAIL reset_enables: got %b expected 0000", {RegWrite, MemWrite, IRWrite, PCEn}); else n_pass++;
        n_total++; if (ALUSrcB !== 2'b01) $display("FAIL reset_alusrcb: got %b expected 01", ALUSrcB); else n_pass++;
        reset = 1'b0; #1;
        n_total++; if ({IRWrite, PCEn} !== 2'b11)
            $display("FAIL release_irwrite: got %b expected 11", {IRWrite, PCEn}); else n_pass++;
    endtask

    task automatic test_rtype();
        int st[5] = '{0, 1, 6, 7, 0};
        for (int i = 0; i < 5; i++) begin
            // Op is garbage outside DECODE to show it is ignored there
            Op = (i == 1) ? 6'b000000 : 6'b100011; MemReady = 1'b1; #1;
            n_total++; if (State !== st[i][3:0]) $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, State, st[i]); else n_pass++;
            n_total++; if (RegWrite !== (i == 3)) $display("FAIL rtype_regwrite[%0d]: got %b expected %b", i, RegWrite, (i == 3)); else n_pass++;
            if (i == 1) begin
                n_total++; if (ALUSrcB !== 2'b11) $display("FAIL decode_alusrcb: got %b expected 11", ALUSrcB); else n_pass++;
            end
            if (i == 2) begin
                n_total++; if ({ALUOp, ALUSrcA, ALUSrcB} !== 5'b10_1_00)
                    $display("FAIL exec_alu: got %b expected 10100", {ALUOp, ALUSrcA, ALUSrcB}); else n_pass++;
            end
            if (i == 3) begin
                n_total++; if ({RegDst, MemtoReg, InstrDone} !== 3'b101)
                    $display("FAIL aluwb_ctl: got %b expected 101", {RegDst, MemtoReg, InstrDone}); else n_pass++;
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_lw();
        int st[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
        bit mr[8] = '{1, 1, 1, 0, 0, 1, 1, 1};
        Op = 6'b100011;
        for (int i = 0; i < 8; i++) begin
            MemReady = mr[i]; #1;
            n_total++; if (State !== st[i][3:0]) $display("FAIL lw_state[%0d]: got %0d expected %0d", i, State, st[i]); else n_pass++;
            n_total++; if (RegWrite !== (st[i] == 4 && i == 6)) $display("FAIL lw_regwrite[%0d]: got %b", i, RegWrite); else n_pass++;
            n_total++; if (InstrDone !== (i == 6)) $display("FAIL lw_done[%0d]: got %b expected %b", i, InstrDone, (i == 6)); else n_pass++;
            if (i == 2) begin
                n_total++; if ({ALUSrcA, ALUSrcB} !== 3'b1_10)
                    $display("FAIL memadr_src: got %b expected 110", {ALUSrcA, ALUSrcB}); else n_pass++;
            end
            if (i >= 3 && i <= 5) begin
                n_total++; if ({IorD, MemWrite} !== 2'b10) $display("FAIL memrd_ctl[%0d]: got %b expected 10", i, {IorD, MemWrite}); else n_pass++;
            end
            if (i == 6) begin
                n_total++; if ({MemtoReg, RegDst} !== 2'b10) $display("FAIL memwb_ctl: got %b expected 10", {MemtoReg, RegDst}); else n_pass++;
            end
            if (i < 7) @(negedge clk);
        end
    endtask

    task automatic test_beq(input logic z);
        int st[4] = '{0, 1, 8, 0};
        Op = 6'b000100; MemReady = 1'b1; Zero = z;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++; if (State !== st[i][3:0]) $display("FAIL beq_state[%0d]: got %0d expected %0d", i, State, st[i]); else n_pass++;
            if (i == 1) begin
                n_total++; if (PCEn !== 1'b0) $display("FAIL beq_decode_pcen: got %b expected 0", PCEn); else n_pass++;
            end
            if (i == 2) begin
                n_total++; if ({ALUOp, PCSrc, ALUSrcA, ALUSrcB} !== 7'b01_01_1_00)
                    $display("FAIL beq_ctl: got %b expected 0101100", {ALUOp, PCSrc, ALUSrcA, ALUSrcB}); else n_pass++;
                n_total++; if (PCEn !== z) $display("FAIL beq_pcen(zero=%b): got %b expected %b", z, PCEn, z); else n_pass++;
                n_total++; if ({InstrDone, RegWrite} !== 2'b10) $display("FAIL beq_done: got %b expected 10", {InstrDone, RegWrite}); else n_pass++;
            end
            if (i < 3) @(negedge clk);
        end
        Zero = 1'b0;
    endtask

    task automatic test_sw();
        int st[6] = '{0, 1, 2, 5, 5, 0};
        bit mr[6] = '{1, 1, 1, 0, 1, 1};
        Op = 6'b101011;
        for (int i = 0; i < 6; i++) begin
            MemReady = mr[i]; #1;
            n_total++; if (State !== st[i][3:0]) $display("FAIL sw_state[%0d]: got %0d expected %0d", i, State, st[i]); else n_pass++;
            n_total++; if (MemWrite !== (i == 3 || i == 4)) $display("FAIL sw_memwrite[%0d]: got %b", i, MemWrite); else n_pass++;
            n_total++; if (InstrDone !== (i == 4)) $display("FAIL sw_done[%0d]: got %b expected %b", i, InstrDone, (i == 4)); else n_pass++;
            if (i == 3) begin
                n_total++; if ({IorD, RegWrite} !== 2'b10) $display("FAIL memwr_ctl: got %b expected 10", {IorD, RegWrite}); else n_pass++;
            end
            if (i < 5) @(negedge clk);
        end
    endtask

    task automatic test_jump();
        int st[4] = '{0, 1, 11, 0};
        Op = 6'b000010; MemReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++; if (State !== st[i][3:0]) $display("FAIL j_state[%0d]: got %0d expected %0d", i, State, st[i]); else n_pass++;
            if (i == 2) begin
                n_total++; if ({PCSrc, PCEn, InstrDone} !== 4'b10_1_1)
                    $display("FAIL j_ctl: got %b expected 1011", {PCSrc, PCEn, InstrDone}); else n_pass++;
            end
            if (i < 3) @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        Op = 6'b111111; MemReady = 1'b1; #1;
        @(negedge clk); #1;
        n_total++; if (State !== 4'd1) $display("FAIL ill_state_decode: got %0d expected 1", State); else n_pass++;
        n_total++; if ({IllegalOp, InstrDone} !== 2'b11) $display("FAIL ill_pulse: got %b expected 11", {IllegalOp, InstrDone}); else n_pass++;
        n_total++; if ({RegWrite, MemWrite, PCEn, IRWrite} !== 4'b0000)
            $display("FAIL ill_writes: got %b expected 0000", {RegWrite, MemWrite, PCEn, IRWrite}); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (State !== 4'd0) $display("FAIL ill_next: got %0d expected 0", State); else n_pass++;
        n_total++; if (IllegalOp !== 1'b0) $display("FAIL ill_clear: got %b expected 0", IllegalOp); else n_pass++;
    endtask

    task automatic test_reset_mid();
        Op = 6'b101011; MemReady = 1'b1;
        repeat (3) @(negedge clk);
        MemReady = 1'b0; #1;
        n_total++; if ({State, MemWrite} !== 5'b0101_1) $display("FAIL rmid_pre: got %b expected 01011", {State, MemWrite}); else n_pass++;
        reset = 1'b1; #1;
        n_total++; if ({MemWrite, InstrDone, PCEn, IorD} !== 4'b0000)
            $display("FAIL rmid_forced: got %b expected 0000", {MemWrite, InstrDone, PCEn, IorD}); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (State !== 4'd0) $display("FAIL rmid_state: got %0d expected 0", State); else n_pass++;
        reset = 1'b0; MemReady = 1'b1; #1;
        n_total++; if (IRWrite !== 1'b1) $display("FAIL rmid_release: got %b expected 1", IRWrite); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_sw();
        test_jump();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
